// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents:
//   arb_state_e : arbiter FSM state encoding (idle / byte offered / waiting for next byte)
//   id_width()  : width of a port index for a given port count (at least 1 bit)
//   cnt_width() : width needed to hold a counter limit without wrapping
//   MainClk/Baud: reference clock and baud constants for the companion transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StHold
  } arb_state_e;

  localparam int unsigned MainClk = 16;
  localparam int unsigned Baud    = 1;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i   : request vector, one bit per port
//   ptr_i   : last-served port; the search starts at ptr_i+1 and wraps
//   gnt_o   : one-hot grant (all zero when nothing requests)
//   idx_o   : index of the granted port (0 when nothing requests)
//   valid_o : some port was granted
module rr_arbiter import uart_pkg::*; #(
  parameter int unsigned NumPorts = 4,
  localparam int unsigned IdW = id_width(NumPorts)
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [IdW-1:0]      ptr_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [IdW-1:0]      idx_o,
  output logic                valid_o
);

  always_comb begin
    int unsigned    cand;
    logic [IdW-1:0] cand_idx;
    logic           found;
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // k = 1 .. NumPorts visits ptr+1 first and the pointer's own port last.
    for (int unsigned k = 1; k <= NumPorts; k++) begin
      cand     = (32'(ptr_i) + k) % NumPorts;
      cand_idx = IdW'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NumPorts byte-stream requesters.
// Round-robin arbitration with message locking: a winning port keeps the
// transmitter until it sends a byte marked last, until MaxBurst bytes have
// gone out, or until it leaves the transmitter idle for GapTimeout cycles.
// Ports:
//   clk_i        : system clock
//   rst_i        : synchronous reset, active high
//   req_valid_i  : per-port byte available
//   req_data_i   : per-port byte, port i in bits [8i+7:8i]
//   req_last_i   : byte is the final byte of its message
//   req_ready_o  : per-port accept (transfer on valid & ready at a rising edge)
//   uart_en_o    : byte offered to the transmitter
//   uart_data_o  : registered byte for the transmitter
//   uart_ack_i   : one-cycle accept pulse from the transmitter
//   busy_o       : arbiter is not idle
//   grant_id_o   : currently / last granted port
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int unsigned NumPorts   = 4,
  parameter int unsigned MaxBurst   = 16,
  parameter int unsigned GapTimeout = 1024,
  localparam int unsigned IdW = id_width(NumPorts)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumPorts-1:0]   req_valid_i,
  input  logic [8*NumPorts-1:0] req_data_i,
  input  logic [NumPorts-1:0]   req_last_i,
  output logic [NumPorts-1:0]   req_ready_o,
  output logic                  uart_en_o,
  output logic [7:0]            uart_data_o,
  input  logic                  uart_ack_i,
  output logic                  busy_o,
  output logic [IdW-1:0]        grant_id_o
);

  localparam int unsigned BurstW = cnt_width(MaxBurst);
  localparam int unsigned GapW   = cnt_width(GapTimeout);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MaxBurst);
  localparam logic [GapW-1:0]   GapLimit = GapW'(GapTimeout - 1);

  arb_state_e        state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic [IdW-1:0]    grant_q, grant_d;
  logic [IdW-1:0]    rr_q, rr_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              last_q, last_d;

  logic [7:0]          port_data [NumPorts];
  logic [NumPorts-1:0] arb_gnt;
  logic [IdW-1:0]      arb_idx;
  logic                arb_valid;

  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      port_data[i] = req_data_i[8*i +: 8];
    end
  end

  rr_arbiter #(
    .NumPorts(NumPorts)
  ) u_rr_arbiter (
    .req_i  (req_valid_i),
    .ptr_i  (rr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .valid_o(arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    burst_d     = burst_q;
    gap_d       = gap_q;
    last_d      = last_q;
    req_ready_o = '0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          req_ready_o = arb_gnt;
          data_d      = port_data[arb_idx];
          grant_d     = arb_idx;
          last_d      = req_last_i[arb_idx];
          burst_d     = BurstW'(1);
          gap_d       = '0;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (uart_ack_i) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (last_q || ((MaxBurst != 0) && (burst_q == BurstMax))) begin
          rr_d    = grant_q;
          gap_d   = '0;
          state_d = StIdle;
        end else begin
          req_ready_o[grant_q] = 1'b1;
          if (req_valid_i[grant_q]) begin
            data_d  = port_data[grant_q];
            last_d  = req_last_i[grant_q];
            gap_d   = '0;
            state_d = StSend;
            // Saturate so an unlimited burst cannot wrap the counter.
            if (burst_q != '1) begin
              burst_d = burst_q + BurstW'(1);
            end
          end else if (GapTimeout != 0) begin
            if (gap_q == GapLimit) begin
              rr_d    = grant_q;
              gap_d   = '0;
              state_d = StIdle;
            end else begin
              gap_d = gap_q + GapW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // No transfer may complete on a reset edge: the byte would be lost.
    if (rst_i) begin
      req_ready_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      data_q  <= 8'h00;
      grant_q <= '0;
      rr_q    <= IdW'(NumPorts - 1);
      burst_q <= '0;
      gap_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
    end
  end

  assign uart_en_o   = (state_q == StSend);
  assign busy_o      = (state_q != StIdle);
  assign uart_data_o = data_q;
  assign grant_id_o  = grant_q;

endmodule
